fifo_wr_arb: RTL and testbench

- Write-side round-robin arbiter/scheduler feeding the DAC sample async FIFO's write port. Runs in the write clock domain.
- Shares one FIFO between NREQ sample sources (e.g. L/R channels, test tone) using burst grants.
- Tags each word with the source channel ID so the read side can demultiplex.
- Raises a sticky stall flag when the FIFO stays full too long.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_wr_arb_rr_pick.sv | 26 ++
 rtl/fifo_wr_arb.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants and helpers for the FIFO write-side arbiter
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Wide enough for burst_cnt with BURST up to 16
  localparam int BURST_CW = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - rotate-priority picker: first valid requester at or after rr_ptr
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  sel,
  output logic            any_valid
);

  logic [IDW-1:0] idx;

  // Scan from farthest to nearest so the nearest valid requester wins
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (valid[idx]) sel = idx;
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter feeding the DAC sample FIFO write port
// Optional per-requester word counters: FIFO_WR_ARB_STATS_EN
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = 24,
  parameter int IDW       = 1,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   stall_clr,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_write_en,
  output logic [IDW+DWIDTH-1:0]  fifo_wdata,
  output logic [IDW-1:0]         active_id,
  output logic                   busy,
  output logic                   stall_flag
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NREQ*16-1:0]     grant_cnt
`endif
);

  localparam int SCW = clog2(STALL_MAX + 1);

  generate
    if (IDW != ((clog2(NREQ) < 1) ? 1 : clog2(NREQ))) begin : g_idw_check
      $error("IDW must equal max(1, clog2(NREQ))");
    end
  endgenerate

  logic [0:0]          state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      pick_id;
  logic [IDW-1:0]      next_ptr;
  logic                any_valid;
  logic [BURST_CW-1:0] burst_cnt;
  logic [SCW-1:0]      stall_cnt;
  logic                in_grant;
  logic                granted_valid;
  logic                can_accept;
  logic                last_word;
  logic                blocked;
  logic                stall_set;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .sel       (pick_id),
    .any_valid (any_valid)
  );

  assign in_grant      = (state == ST_GRANT);
  assign granted_valid = req_valid[active_id];
  // Gated by rst so the word presented in a reset cycle is never written
  assign can_accept    = in_grant && enable && !fifo_full && !rst;
  assign req_ready     = can_accept ? (NREQ'(1) << active_id) : '0;
  assign fifo_write_en = can_accept && granted_valid;
  assign fifo_wdata    = {active_id, req_data[active_id*DWIDTH +: DWIDTH]};
  assign busy          = in_grant;

  assign next_ptr  = (active_id == IDW'(NREQ - 1)) ? '0 : active_id + 1'b1;
  assign last_word = (burst_cnt == BURST_CW'(BURST - 1));
  assign blocked   = fifo_full && |req_valid;
  assign stall_set = blocked && (stall_cnt == SCW'(STALL_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      active_id <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && any_valid) begin
            active_id <= pick_id;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        default: begin
          if (!enable || !granted_valid || (fifo_write_en && last_word)) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end else if (fifo_write_en) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (blocked) begin
      if (stall_cnt != SCW'(STALL_MAX)) stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Set beats clear when both land in the same cycle
  always_ff @(posedge clk) begin
    if (rst)            stall_flag <= 1'b0;
    else if (stall_set) stall_flag <= 1'b1;
    else if (stall_clr) stall_flag <= 1'b0;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
      always_ff @(posedge clk) begin
        if (rst || stats_clr)
          cnt_q[i] <= '0;
        else if (fifo_write_en && (active_id == IDW'(i)))
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
      assign grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        stall_clr;
  logic [1:0]  req_valid;
  logic [47:0] req_data;
  logic [1:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [24:0] fifo_wdata;
  logic [0:0]  active_id;
  logic        busy;
  logic        stall_flag;
`ifdef FIFO_WR_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  fifo_wr_arb dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .stall_clr     (stall_clr),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_wdata    (fifo_wdata),
    .active_id     (active_id),
    .busy          (busy),
    .stall_flag    (stall_flag)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .grant_cnt     (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_we;
    logic        exp_id;
    logic [24:0] exp_wd;

    rst = 1'b1; enable = 1'b0; stall_clr = 1'b0; req_valid = 2'b00;
    req_data = '0; fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    cyc(); cyc();
    samp();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", fifo_write_en, 0);
    chk("rst_id", active_id, 0);
    chk("rst_stall", stall_flag, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Both requesters valid: 0x4, idle, 1x4, idle, ...
    enable = 1'b1; req_valid = 2'b11; req_data = {24'h222222, 24'h111111};
    for (int t = 0; t < 20; t++) begin
      samp();
      exp_we = (t % 5) != 0;
      exp_id = ((t / 5) % 2) == 1;
      exp_wd = {exp_id, exp_id ? 24'h222222 : 24'h111111};
      chk($sformatf("rr_we[%0d]", t), fifo_write_en, exp_we);
      if (exp_we) chk($sformatf("rr_wd[%0d]", t), fifo_wdata, exp_wd);
      cyc();
    end
    enable = 1'b0; req_valid = 2'b00;
    cyc();

    // Reset while requester 1 is presenting word 2
    enable = 1'b1; req_valid = 2'b11;
    for (int t = 0; t < 8; t++) begin
      samp();
      exp_we = (t % 5) != 0;
      chk($sformatf("mb_we[%0d]", t), fifo_write_en, exp_we);
      cyc();
    end
    rst = 1'b1;
    samp();
    chk("mb_rst_we", fifo_write_en, 0);
    chk("mb_rst_ready", req_ready, 0);
    cyc();
    rst = 1'b0;
    samp();
    chk("mb_post_busy", busy, 0);
    chk("mb_post_we", fifo_write_en, 0);
    chk("mb_post_id", active_id, 0);
    cyc();
    samp();
    chk("mb_regrant_busy", busy, 1);
    chk("mb_regrant_id", active_id, 0);
    chk("mb_regrant_wd", fifo_wdata, {1'b0, 24'h111111});
    cyc();
    enable = 1'b0;
    samp();
    chk("en_off_ready", req_ready, 0);
    chk("en_off_we", fifo_write_en, 0);
    cyc();
    samp();
    chk("en_off_busy", busy, 0);
    req_valid = 2'b00;
    cyc();

    // Only requester 1 valid
    enable = 1'b1; req_valid = 2'b10; req_data = {24'hABCDEF, 24'h000000};
    for (int t = 0; t < 10; t++) begin
      samp();
      exp_we = (t % 5) != 0;
      chk($sformatf("r1_we[%0d]", t), fifo_write_en, exp_we);
      if (exp_we) begin
        chk($sformatf("r1_wd[%0d]", t), fifo_wdata, 25'h1ABCDEF);
        chk($sformatf("r1_ready[%0d]", t), req_ready, 2'b10);
      end
      cyc();
    end
    req_valid = 2'b00;
    cyc();

    // FIFO full for 10 cycles after two words of a burst
    req_valid = 2'b01; req_data = {24'h000000, 24'h000123};
    samp(); chk("ff_idle_we", fifo_write_en, 0); cyc();
    samp(); chk("ff_w0", fifo_write_en, 1); cyc();
    samp(); chk("ff_w1", fifo_write_en, 1); cyc();
    fifo_full = 1'b1;
    for (int t = 0; t < 10; t++) begin
      samp();
      chk($sformatf("ff_hold_we[%0d]", t), fifo_write_en, 0);
      chk($sformatf("ff_hold_ready[%0d]", t), req_ready, 0);
      chk($sformatf("ff_hold_busy[%0d]", t), busy, 1);
      cyc();
    end
    fifo_full = 1'b0;
    samp(); chk("ff_w2", fifo_write_en, 1); cyc();
    samp(); chk("ff_w3", fifo_write_en, 1); cyc();
    samp();
    chk("ff_end_we", fifo_write_en, 0);
    chk("ff_end_busy", busy, 0);
    req_valid = 2'b00;
    cyc();

    // Stall flag after 64 blocked cycles
    req_valid = 2'b01; fifo_full = 1'b1;
    for (int t = 0; t < 63; t++) cyc();
    samp();
    chk("stall_63", stall_flag, 0);
    cyc();
    samp();
    chk("stall_64", stall_flag, 1);
    fifo_full = 1'b0; req_valid = 2'b00;
    cyc(); cyc(); cyc();
    samp();
    chk("stall_sticky", stall_flag, 1);
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    samp();
    chk("stall_cleared", stall_flag, 0);
    cyc();

    // Requester 0 drops valid after 2 words; requester 1 follows
    req_valid = 2'b01; req_data = {24'h000666, 24'h000555};
    samp(); chk("drop_idle_we", fifo_write_en, 0); cyc();
    req_valid = 2'b11;
    samp(); chk("drop_w0", fifo_write_en, 1); chk("drop_w0_id", active_id, 0); cyc();
    samp(); chk("drop_w1", fifo_write_en, 1); cyc();
    req_valid = 2'b10;
    samp();
    chk("drop_gap_we", fifo_write_en, 0);
    chk("drop_gap_busy", busy, 1);
    cyc();
    samp();
    chk("drop_idle_busy", busy, 0);
    cyc();
    samp();
    chk("drop_next_id", active_id, 1);
    chk("drop_next_we", fifo_write_en, 1);
    chk("drop_next_wd", fifo_wdata, 25'h1000666);
    req_valid = 2'b00;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
